// File: rtl/maquina_expendedora_multi_pkg.sv
// Shared definitions for the multi-denomination vending controller:
// coin codes and their values, and the FSM state encoding.
package maquina_pkg;

  // Coin codes, shared by the coin acceptor input and the change output.
  localparam logic [1:0] MONEDA_1  = 2'd0;
  localparam logic [1:0] MONEDA_2  = 2'd1;
  localparam logic [1:0] MONEDA_5  = 2'd2;
  localparam logic [1:0] MONEDA_10 = 2'd3;

  // Controller states.
  localparam logic [1:0] EST_IDLE    = 2'd0;  // no credit held
  localparam logic [1:0] EST_CREDITO = 2'd1;  // credit held, waiting for user
  localparam logic [1:0] EST_ENTREGA = 2'd2;  // one-cycle product dispense
  localparam logic [1:0] EST_CAMBIO  = 2'd3;  // streaming change coins

  // Value in credit units of a coin code.
  function automatic logic [3:0] valor_moneda(input logic [1:0] tipo);
    case (tipo)
      MONEDA_1:  valor_moneda = 4'd1;
      MONEDA_2:  valor_moneda = 4'd2;
      MONEDA_5:  valor_moneda = 4'd5;
      default:   valor_moneda = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/maquina_expendedora_multi_calc_cambio.sv
// Greedy change selector: picks the largest coin whose value does not
// exceed the remaining credit. Purely combinational.
module calc_cambio
  import maquina_pkg::*;
#(
  parameter int CRED_W = 8
) (
  input  logic [CRED_W-1:0] credito,
  output logic [1:0]        tipo,
  output logic [CRED_W-1:0] valor
);

  // Largest-first coin choice; a unit coin always fits, so change is exact.
  // NOTE: every output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    if (credito >= CRED_W'(10))     tipo = MONEDA_10;
    else if (credito >= CRED_W'(5)) tipo = MONEDA_5;
    else if (credito >= CRED_W'(2)) tipo = MONEDA_2;
    else                            tipo = MONEDA_1;
    valor = CRED_W'(valor_moneda(tipo));
  end

endmodule

// File: rtl/maquina_expendedora_multi.sv
// Vending-machine controller: multi-denomination coin intake with a credit
// ceiling, N_PROD priced products, cancel/refund, and change paid out as a
// largest-first coin stream. All outputs are registered.
module maquina_expendedora_multi
  import maquina_pkg::*;
#(
  parameter int CRED_W     = 8,
  parameter int MAX_CREDIT = 100,
  parameter int N_PROD     = 4,
  parameter int PROD_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1,
  parameter logic [N_PROD*CRED_W-1:0] PRECIOS = {8'd15, 8'd12, 8'd8, 8'd5}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              moneda_valida,
  input  logic [1:0]        moneda_tipo,
  input  logic              seleccion_valida,
  input  logic [PROD_W-1:0] seleccion,
  input  logic              cancelar,
  output logic              producto_valido,
  output logic [PROD_W-1:0] producto,
  output logic              cambio_valido,
  output logic [1:0]        cambio_tipo,
  output logic [CRED_W-1:0] credito,
  output logic              rechazo_moneda,
  output logic              sin_credito,
  output logic              ocupado
);

  localparam int N_IDX = 2 ** PROD_W;

  // Parameter sanity checks at elaboration.
  if (MAX_CREDIT >= 2 ** CRED_W) begin : g_chk_max
    $error("MAX_CREDIT does not fit in CRED_W bits");
  end
  if (CRED_W < 4) begin : g_chk_w
    $error("CRED_W must hold the largest coin value (10)");
  end
  if (N_IDX < N_PROD) begin : g_chk_pw
    $error("PROD_W too narrow for N_PROD");
  end
  for (genvar p = 0; p < N_PROD; p++) begin : g_chk_precio
    if (PRECIOS[p*CRED_W +: CRED_W] > MAX_CREDIT) begin : g_err
      $error("product price exceeds MAX_CREDIT");
    end
  end

  // Price and index-valid tables over the full selector range, so an
  // out-of-range index simply looks up an invalid entry.
  logic [CRED_W-1:0] precio_tab [N_IDX];
  logic [N_IDX-1:0]  indice_ok;

  for (genvar i = 0; i < N_IDX; i++) begin : g_precios
    if (i < N_PROD) begin : g_val
      assign precio_tab[i] = PRECIOS[i*CRED_W +: CRED_W];
      assign indice_ok[i]  = 1'b1;
    end else begin : g_inv
      assign precio_tab[i] = '0;
      assign indice_ok[i]  = 1'b0;
    end
  end

  logic [1:0]        estado, estado_sig;
  logic [CRED_W-1:0] credito_sig;
  logic [PROD_W-1:0] producto_sig;
  logic [1:0]        cambio_tipo_sig;
  logic              producto_valido_sig, cambio_valido_sig;
  logic              rechazo_sig, sin_credito_sig, ocupado_sig;

  logic [1:0]        cambio_tipo_calc;
  logic [CRED_W-1:0] cambio_valor;
  logic [CRED_W:0]   suma;
  logic              moneda_cabe, puede_vender;

  calc_cambio #(.CRED_W(CRED_W)) u_calc_cambio (
    .credito (credito),
    .tipo    (cambio_tipo_calc),
    .valor   (cambio_valor)
  );

  // One bit wider than the credit register so the ceiling test cannot wrap.
  assign suma         = {1'b0, credito} + (CRED_W+1)'(valor_moneda(moneda_tipo));
  assign moneda_cabe  = (suma <= (CRED_W+1)'(MAX_CREDIT));
  assign puede_vender = indice_ok[seleccion] && (credito >= precio_tab[seleccion]);

  // Next-state and next-output decision; cancel beats select beats coin.
  always_comb begin
    estado_sig          = estado;
    credito_sig         = credito;
    producto_sig        = producto;
    cambio_tipo_sig     = cambio_tipo;
    producto_valido_sig = 1'b0;
    cambio_valido_sig   = 1'b0;
    rechazo_sig         = 1'b0;
    sin_credito_sig     = 1'b0;
    case (estado)
      EST_IDLE, EST_CREDITO: begin
        if (cancelar) begin
          rechazo_sig = moneda_valida;
          if (credito != '0) estado_sig = EST_CAMBIO;
        end else if (seleccion_valida) begin
          rechazo_sig = moneda_valida;
          if (puede_vender) begin
            estado_sig          = EST_ENTREGA;
            credito_sig         = credito - precio_tab[seleccion];
            producto_valido_sig = 1'b1;
            producto_sig        = seleccion;
          end else begin
            sin_credito_sig = 1'b1;
          end
        end else if (moneda_valida) begin
          if (moneda_cabe) begin
            credito_sig = suma[CRED_W-1:0];
            estado_sig  = EST_CREDITO;
          end else begin
            rechazo_sig = 1'b1;
          end
        end
      end
      EST_ENTREGA: begin
        rechazo_sig = moneda_valida;
        estado_sig  = (credito != '0) ? EST_CAMBIO : EST_IDLE;
      end
      EST_CAMBIO: begin
        rechazo_sig = moneda_valida;
        if (credito == '0) begin
          estado_sig = EST_IDLE;
        end else begin
          cambio_valido_sig = 1'b1;
          cambio_tipo_sig   = cambio_tipo_calc;
          credito_sig       = credito - cambio_valor;
          if (credito == cambio_valor) estado_sig = EST_IDLE;
        end
      end
      default: estado_sig = EST_IDLE;
    endcase
  end

  assign ocupado_sig = (estado_sig == EST_ENTREGA) || (estado_sig == EST_CAMBIO);

  // State and output registers; reset aborts any dispense or change in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado          <= EST_IDLE;
      credito         <= '0;
      producto        <= '0;
      cambio_tipo     <= MONEDA_1;
      producto_valido <= 1'b0;
      cambio_valido   <= 1'b0;
      rechazo_moneda  <= 1'b0;
      sin_credito     <= 1'b0;
      ocupado         <= 1'b0;
    end else begin
      estado          <= estado_sig;
      credito         <= credito_sig;
      producto        <= producto_sig;
      cambio_tipo     <= cambio_tipo_sig;
      producto_valido <= producto_valido_sig;
      cambio_valido   <= cambio_valido_sig;
      rechazo_moneda  <= rechazo_sig;
      sin_credito     <= sin_credito_sig;
      ocupado         <= ocupado_sig;
    end
  end

endmodule

// File: tb/tb_maquina_expendedora_multi.sv
// Bench for maquina_expendedora_multi: directed scenarios plus a randomized
// run, all checked against an event-schedule model of the vending rules.
module tb_maquina_expendedora_multi;

  localparam int CRED_W = 8;
  localparam int N_PROD = 4;
  localparam int PROD_W = 3;  // wider than needed so out-of-range indices can be requested
  localparam int MAXC   = 100;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              moneda_valida;
  logic [1:0]        moneda_tipo;
  logic              seleccion_valida;
  logic [PROD_W-1:0] seleccion;
  logic              cancelar;
  logic              producto_valido;
  logic [PROD_W-1:0] producto;
  logic              cambio_valido;
  logic [1:0]        cambio_tipo;
  logic [CRED_W-1:0] credito;
  logic              rechazo_moneda;
  logic              sin_credito;
  logic              ocupado;

  maquina_expendedora_multi #(
    .CRED_W(CRED_W), .MAX_CREDIT(MAXC), .N_PROD(N_PROD), .PROD_W(PROD_W),
    .PRECIOS({8'd15, 8'd12, 8'd8, 8'd5})
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .moneda_valida(moneda_valida), .moneda_tipo(moneda_tipo),
    .seleccion_valida(seleccion_valida), .seleccion(seleccion), .cancelar(cancelar),
    .producto_valido(producto_valido), .producto(producto),
    .cambio_valido(cambio_valido), .cambio_tipo(cambio_tipo), .credito(credito),
    .rechazo_moneda(rechazo_moneda), .sin_credito(sin_credito), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int precios [4] = '{5, 8, 12, 15};
  int valores [4] = '{1, 2, 5, 10};

  // Reference model: credit as a plain integer, plus a queue holding the
  // expected outputs of every cycle the machine spends busy.
  typedef struct {
    bit cam_v;
    int cam_t;
    int credit;
    bit busy;
  } evento_t;

  evento_t m_q[$];
  int m_credit;
  bit e_prod_v, e_cam_v, e_rech, e_sinc, e_ocup;
  int e_prod, e_cam_t;

  function automatic int codigo(int v);
    case (v)
      10:      return 3;
      5:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  task automatic push_change(int r);
    while (r > 0) begin
      int v;
      v = (r >= 10) ? 10 : (r >= 5) ? 5 : (r >= 2) ? 2 : 1;
      r -= v;
      m_q.push_back('{1'b1, codigo(v), r, r > 0});
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_credit = 0;
    e_prod_v = 0; e_cam_v = 0; e_rech = 0; e_sinc = 0; e_ocup = 0;
    e_prod = 0; e_cam_t = 0;
  endtask

  task automatic model_update(bit mv, int mt, bit sv, int s, bit c);
    evento_t e;
    e_prod_v = 0; e_cam_v = 0; e_rech = 0; e_sinc = 0; e_ocup = 0;
    if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_credit = e.credit;
      e_ocup   = e.busy;
      e_cam_v  = e.cam_v;
      if (e.cam_v) e_cam_t = e.cam_t;
      e_rech   = mv;
    end else if (c) begin
      e_rech = mv;
      if (m_credit > 0) begin
        e_ocup = 1;
        push_change(m_credit);
      end
    end else if (sv) begin
      e_rech = mv;
      if (s < N_PROD && m_credit >= precios[s]) begin
        m_credit -= precios[s];
        e_prod_v = 1;
        e_prod   = s;
        e_ocup   = 1;
        m_q.push_back('{1'b0, 0, m_credit, m_credit > 0});
        push_change(m_credit);
      end else begin
        e_sinc = 1;
      end
    end else if (mv) begin
      if (m_credit + valores[mt] <= MAXC) m_credit += valores[mt];
      else e_rech = 1;
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic step(bit mv, int mt, bit sv, int s, bit c);
    moneda_valida    = mv;
    moneda_tipo      = 2'(mt);
    seleccion_valida = sv;
    seleccion        = 3'(s);
    cancelar         = c;
    @(posedge clk);
    model_update(mv, mt, sv, s, c);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic coin(int mt);
    step(1, mt, 0, 0, 0);
  endtask

  // Idle until the machine is no longer busy, counting change strobes.
  task automatic drain(output int n, output bit ok);
    n = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (cambio_valido) n++;
      if (!ocupado) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 0;
    moneda_valida = 0; moneda_tipo = 0; seleccion_valida = 0; seleccion = 0; cancelar = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    n_cmp += 8;
    if (credito !== 0)         begin n_err++; $display("FAIL reset_credito: got %0d want 0", credito); end
    if (producto_valido !== 0) begin n_err++; $display("FAIL reset_prod_v: got %0b want 0", producto_valido); end
    if (producto !== 0)        begin n_err++; $display("FAIL reset_producto: got %0d want 0", producto); end
    if (cambio_valido !== 0)   begin n_err++; $display("FAIL reset_cam_v: got %0b want 0", cambio_valido); end
    if (cambio_tipo !== 0)     begin n_err++; $display("FAIL reset_cam_t: got %0d want 0", cambio_tipo); end
    if (rechazo_moneda !== 0)  begin n_err++; $display("FAIL reset_rech: got %0b want 0", rechazo_moneda); end
    if (sin_credito !== 0)     begin n_err++; $display("FAIL reset_sinc: got %0b want 0", sin_credito); end
    if (ocupado !== 0)         begin n_err++; $display("FAIL reset_ocup: got %0b want 0", ocupado); end
  endtask

  task automatic test_vend_change();
    coin(3);
    coin(2);
    n_cmp++;
    if (credito !== 15) begin n_err++; $display("FAIL vend_credit15: got %0d want 15", credito); end
    step(0, 0, 1, 0, 0);
    n_cmp += 4;
    if (producto_valido !== 1) begin n_err++; $display("FAIL vend_prod_v: got %0b want 1", producto_valido); end
    if (producto !== 0)        begin n_err++; $display("FAIL vend_prod: got %0d want 0", producto); end
    if (credito !== 10)        begin n_err++; $display("FAIL vend_credit10: got %0d want 10", credito); end
    if (ocupado !== 1)         begin n_err++; $display("FAIL vend_ocup: got %0b want 1", ocupado); end
    idle();
    n_cmp += 2;
    if (producto_valido !== 0) begin n_err++; $display("FAIL vend_prod_1cyc: got %0b want 0", producto_valido); end
    if (cambio_valido !== 0)   begin n_err++; $display("FAIL vend_gap_cam: got %0b want 0", cambio_valido); end
    idle();
    n_cmp += 4;
    if (cambio_valido !== 1) begin n_err++; $display("FAIL vend_cam_v: got %0b want 1", cambio_valido); end
    if (cambio_tipo !== 3)   begin n_err++; $display("FAIL vend_cam_t: got %0d want 3", cambio_tipo); end
    if (credito !== 0)       begin n_err++; $display("FAIL vend_credit0: got %0d want 0", credito); end
    if (ocupado !== 0)       begin n_err++; $display("FAIL vend_idle: got %0b want 0", ocupado); end
    idle();
    n_cmp++;
    if (cambio_valido !== 0) begin n_err++; $display("FAIL vend_one_strobe: got %0b want 0", cambio_valido); end
  endtask

  task automatic test_credit_ceiling();
    int n;
    bit ok;
    repeat (9) coin(3);
    coin(2); coin(1); coin(0);
    n_cmp++;
    if (credito !== 98) begin n_err++; $display("FAIL ceil_98: got %0d want 98", credito); end
    coin(2);
    n_cmp += 2;
    if (rechazo_moneda !== 1) begin n_err++; $display("FAIL ceil_rej5: got %0b want 1", rechazo_moneda); end
    if (credito !== 98)       begin n_err++; $display("FAIL ceil_hold98: got %0d want 98", credito); end
    coin(1);
    n_cmp += 2;
    if (rechazo_moneda !== 0) begin n_err++; $display("FAIL ceil_acc2: got %0b want 0", rechazo_moneda); end
    if (credito !== 100)      begin n_err++; $display("FAIL ceil_100: got %0d want 100", credito); end
    coin(0);
    n_cmp += 2;
    if (rechazo_moneda !== 1) begin n_err++; $display("FAIL ceil_rej1: got %0b want 1", rechazo_moneda); end
    if (credito !== 100)      begin n_err++; $display("FAIL ceil_hold100: got %0d want 100", credito); end
    step(0, 0, 0, 0, 1);
    drain(n, ok);
    n_cmp += 2;
    if (!ok || n != 10) begin n_err++; $display("FAIL ceil_refund: got %0d coins done=%0b want 10 done=1", n, ok); end
    if (credito !== 0)  begin n_err++; $display("FAIL ceil_refund0: got %0d want 0", credito); end
  endtask

  task automatic test_no_credit();
    int n;
    bit ok;
    coin(2); coin(1);
    step(0, 0, 1, 3, 0);
    n_cmp += 3;
    if (sin_credito !== 1)     begin n_err++; $display("FAIL nocred_sinc: got %0b want 1", sin_credito); end
    if (credito !== 7)         begin n_err++; $display("FAIL nocred_credit: got %0d want 7", credito); end
    if (producto_valido !== 0) begin n_err++; $display("FAIL nocred_prod: got %0b want 0", producto_valido); end
    coin(3);
    for (int s = N_PROD; s < 8; s++) begin
      step(0, 0, 1, s, 0);
      n_cmp += 2;
      if (sin_credito !== 1) begin n_err++; $display("FAIL badidx_%0d_sinc: got %0b want 1", s, sin_credito); end
      if (credito !== 17)    begin n_err++; $display("FAIL badidx_%0d_credit: got %0d want 17", s, credito); end
    end
    idle();
    n_cmp++;
    if (sin_credito !== 0) begin n_err++; $display("FAIL nocred_pulse: got %0b want 0", sin_credito); end
    step(0, 0, 0, 0, 1);
    drain(n, ok);
    n_cmp++;
    if (!ok || n != 3) begin n_err++; $display("FAIL nocred_refund: got %0d coins done=%0b want 3 done=1", n, ok); end
  endtask

  task automatic test_cancel();
    int tipos [4] = '{3, 2, 1, 0};
    int resto [4] = '{8, 3, 1, 0};
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if (ocupado !== 0) begin n_err++; $display("FAIL cancel_noop: got %0b want 0", ocupado); end
    coin(3); coin(2); coin(1); coin(0);
    step(0, 0, 0, 0, 1);
    n_cmp += 2;
    if (ocupado !== 1)  begin n_err++; $display("FAIL cancel_busy: got %0b want 1", ocupado); end
    if (credito !== 18) begin n_err++; $display("FAIL cancel_credit: got %0d want 18", credito); end
    for (int i = 0; i < 4; i++) begin
      idle();
      n_cmp += 4;
      if (cambio_valido !== 1)     begin n_err++; $display("FAIL cancel_c%0d_v: got %0b want 1", i, cambio_valido); end
      if (cambio_tipo !== tipos[i]) begin n_err++; $display("FAIL cancel_c%0d_t: got %0d want %0d", i, cambio_tipo, tipos[i]); end
      if (credito !== resto[i])    begin n_err++; $display("FAIL cancel_c%0d_cr: got %0d want %0d", i, credito, resto[i]); end
      if (ocupado !== (i < 3))     begin n_err++; $display("FAIL cancel_c%0d_busy: got %0b want %0b", i, ocupado, i < 3); end
    end
    idle();
    n_cmp++;
    if (cambio_valido !== 0) begin n_err++; $display("FAIL cancel_end: got %0b want 0", cambio_valido); end
  endtask

  task automatic test_back_to_back();
    coin(2); coin(1); coin(0);
    step(1, 0, 1, 1, 0);
    n_cmp += 4;
    if (producto_valido !== 1) begin n_err++; $display("FAIL coinc_prod_v: got %0b want 1", producto_valido); end
    if (producto !== 1)        begin n_err++; $display("FAIL coinc_prod: got %0d want 1", producto); end
    if (rechazo_moneda !== 1)  begin n_err++; $display("FAIL coinc_rej: got %0b want 1", rechazo_moneda); end
    if (credito !== 0)         begin n_err++; $display("FAIL coinc_credit: got %0d want 0", credito); end
    coin(3);
    n_cmp += 3;
    if (rechazo_moneda !== 1) begin n_err++; $display("FAIL entrega_rej: got %0b want 1", rechazo_moneda); end
    if (credito !== 0)        begin n_err++; $display("FAIL entrega_credit: got %0d want 0", credito); end
    if (ocupado !== 0)        begin n_err++; $display("FAIL entrega_idle: got %0b want 0", ocupado); end
    coin(3); coin(1);
    step(0, 0, 1, 0, 0);
    coin(3);
    n_cmp += 2;
    if (rechazo_moneda !== 1) begin n_err++; $display("FAIL b2b_rej0: got %0b want 1", rechazo_moneda); end
    if (cambio_valido !== 0)  begin n_err++; $display("FAIL b2b_gap: got %0b want 0", cambio_valido); end
    coin(3);
    n_cmp += 3;
    if (rechazo_moneda !== 1) begin n_err++; $display("FAIL b2b_rej1: got %0b want 1", rechazo_moneda); end
    if (cambio_tipo !== 2)    begin n_err++; $display("FAIL b2b_t1: got %0d want 2", cambio_tipo); end
    if (credito !== 2)        begin n_err++; $display("FAIL b2b_cr1: got %0d want 2", credito); end
    coin(3);
    n_cmp += 3;
    if (cambio_tipo !== 1) begin n_err++; $display("FAIL b2b_t2: got %0d want 1", cambio_tipo); end
    if (credito !== 0)     begin n_err++; $display("FAIL b2b_cr2: got %0d want 0", credito); end
    if (ocupado !== 0)     begin n_err++; $display("FAIL b2b_idle: got %0b want 0", ocupado); end
  endtask

  task automatic test_reset_mid_cambio();
    coin(3); coin(2); coin(1); coin(0);
    step(0, 0, 0, 0, 1);
    idle();
    #2 reset_n = 0;
    #1;
    model_reset();
    n_cmp += 3;
    if (cambio_valido !== 0) begin n_err++; $display("FAIL rstmid_cam: got %0b want 0", cambio_valido); end
    if (credito !== 0)       begin n_err++; $display("FAIL rstmid_credit: got %0d want 0", credito); end
    if (ocupado !== 0)       begin n_err++; $display("FAIL rstmid_ocup: got %0b want 0", ocupado); end
    moneda_valida = 0; seleccion_valida = 0; cancelar = 0;
    @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_cmp += 2;
      if (cambio_valido !== 0) begin n_err++; $display("FAIL rstmid_after%0d_cam: got %0b want 0", i, cambio_valido); end
      if (credito !== 0)       begin n_err++; $display("FAIL rstmid_after%0d_cr: got %0d want 0", i, credito); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit mv, sv, c;
      mv = ($urandom_range(0, 99) < 45);
      sv = ($urandom_range(0, 99) < 15);
      c  = ($urandom_range(0, 99) < 4);
      step(mv, $urandom_range(0, 3), sv, $urandom_range(0, 7), c);
      n_cmp += 9;
      if (producto_valido !== e_prod_v) begin n_err++; $display("FAIL rnd%0d_prod_v: got %0b want %0b", i, producto_valido, e_prod_v); end
      if (producto !== e_prod)          begin n_err++; $display("FAIL rnd%0d_prod: got %0d want %0d", i, producto, e_prod); end
      if (cambio_valido !== e_cam_v)    begin n_err++; $display("FAIL rnd%0d_cam_v: got %0b want %0b", i, cambio_valido, e_cam_v); end
      if (cambio_tipo !== e_cam_t)      begin n_err++; $display("FAIL rnd%0d_cam_t: got %0d want %0d", i, cambio_tipo, e_cam_t); end
      if (int'(credito) !== m_credit)   begin n_err++; $display("FAIL rnd%0d_credit: got %0d want %0d", i, credito, m_credit); end
      if (rechazo_moneda !== e_rech)    begin n_err++; $display("FAIL rnd%0d_rech: got %0b want %0b", i, rechazo_moneda, e_rech); end
      if (sin_credito !== e_sinc)       begin n_err++; $display("FAIL rnd%0d_sinc: got %0b want %0b", i, sin_credito, e_sinc); end
      if (ocupado !== e_ocup)           begin n_err++; $display("FAIL rnd%0d_ocup: got %0b want %0b", i, ocupado, e_ocup); end
      if (producto_valido && cambio_valido) begin n_err++; $display("FAIL rnd%0d_exclusive: got both strobes want one", i); end
    end
  endtask

  initial begin
    reset_n = 0;
    test_reset();
    test_vend_change();
    test_credit_ceiling();
    test_no_credit();
    test_cancel();
    test_back_to_back();
    test_reset_mid_cambio();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
